// File: rtl/pulse_burst_pkg.sv
// Shared types and constants for the pulse burst controller.
//   state_e  : controller state (idle / running a burst)
//   MinDiv   : smallest accepted tick period in clocks
//   DefaultM : default divisor / modulo counter width
//   DefaultK : default pulse-count width
package pulse_burst_pkg;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam int unsigned MinDiv   = 2;
   localparam int unsigned DefaultM = 8;
   localparam int unsigned DefaultK = 8;

endpackage

// File: rtl/pulse_burst_ctrl_if.sv
// Request / status bundle between the board-side requester and pulse_burst_ctrl.
//   start, abort     : burst request and early termination (requester -> controller)
//   div, npulse      : tick period and burst length, sampled with an accepted start
//   busy, tick, done : running flag, one-cycle tick, one-cycle normal completion
//   err, pulses      : one-cycle rejected-start flag, ticks emitted in current/last burst
interface pulse_burst_ctrl_if #(
   parameter int unsigned M = pulse_burst_pkg::DefaultM,
   parameter int unsigned K = pulse_burst_pkg::DefaultK
) ();

   logic         start;
   logic         abort;
   logic [M-1:0] div;
   logic [K-1:0] npulse;
   logic         busy;
   logic         tick;
   logic         done;
   logic         err;
   logic [K-1:0] pulses;

   modport master (
      output start, abort, div, npulse,
      input  busy, tick, done, err, pulses
   );

   modport slave (
      input  start, abort, div, npulse,
      output busy, tick, done, err, pulses
   );

endinterface

// File: rtl/divide_prog.sv
// Runtime-programmable modulo-DIV counter, updated on the falling clock edge.
//   CLOCK    : clock (falling edge active)
//   CLEAR    : asynchronous active-low reset
//   EN       : advance the counter this edge
//   SYNC_CLR : synchronously zero the counter and TICK (wins over EN)
//   DIV      : modulus, must be >= 2 whenever EN is high
//   TICK     : registered, high for the cycle after the DIV-2 -> DIV-1 step,
//              i.e. while the counter holds DIV-1
//   PRE_TICK : counter currently holds DIV-2, so the next enabled edge raises TICK
module divide_prog import pulse_burst_pkg::*; #(
   parameter int unsigned M = DefaultM
) (
   input  logic         CLOCK,
   input  logic         CLEAR,
   input  logic         EN,
   input  logic         SYNC_CLR,
   input  logic [M-1:0] DIV,
   output logic         TICK,
   output logic         PRE_TICK
);

   logic [M-1:0] cnt_q, cnt_d;
   logic         tick_q, tick_d;
   logic [M-1:0] div_m1, div_m2;

   assign div_m1 = DIV - M'(1);
   assign div_m2 = DIV - M'(2);

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (SYNC_CLR) begin
         cnt_d = '0;
      end else if (EN) begin
         cnt_d  = (cnt_q == div_m1) ? '0 : cnt_q + M'(1);
         tick_d = (cnt_q == div_m2);
      end
   end

   always_ff @(negedge CLOCK or negedge CLEAR) begin
      if (!CLEAR) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign TICK     = tick_q;
   assign PRE_TICK = (cnt_q == div_m2);

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Burst controller: on an accepted start, emits npulse one-cycle ticks spaced div
// clocks apart, then flags done. All state changes on the falling clock edge.
//   CLOCK : clock (falling edge active)
//   CLEAR : asynchronous active-low reset; a mid-burst reset aborts silently
//   bus   : pulse_burst_ctrl_if slave (start/abort/div/npulse in,
//           busy/tick/done/err/pulses out, all outputs registered)
module pulse_burst_ctrl import pulse_burst_pkg::*; #(
   parameter int unsigned M = DefaultM,
   parameter int unsigned K = DefaultK
) (
   input logic               CLOCK,
   input logic               CLEAR,
   pulse_burst_ctrl_if.slave bus
);

   state_e       state_q, state_d;
   logic [M-1:0] div_q, div_d;
   logic [K-1:0] npulse_q, npulse_d;
   logic [K-1:0] pulses_q, pulses_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         err_q, err_d;

   logic div_tick, div_pre_tick;
   logic last_wrap, run_go;

   // div_tick high means the counter sits at DIV-1, so this edge is a wrap edge.
   assign last_wrap = (state_q == StRun) && div_tick && (pulses_q == npulse_q);
   // Counter only advances while the burst continues; otherwise it is held at zero
   // so an abort or completion also suppresses any coincident tick.
   assign run_go    = (state_q == StRun) && !bus.abort && !last_wrap;

   divide_prog #(
      .M (M)
   ) u_div (
      .CLOCK    (CLOCK),
      .CLEAR    (CLEAR),
      .EN       (run_go),
      .SYNC_CLR (!run_go),
      .DIV      (div_q),
      .TICK     (div_tick),
      .PRE_TICK (div_pre_tick)
   );

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      npulse_d = npulse_q;
      pulses_d = pulses_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if ((bus.div < M'(MinDiv)) || (bus.npulse == '0)) begin
                  err_d = 1'b1;
               end else begin
                  div_d    = bus.div;
                  npulse_d = bus.npulse;
                  pulses_d = '0;
                  busy_d   = 1'b1;
                  state_d  = StRun;
               end
            end
         end
         StRun: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (last_wrap) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (div_pre_tick) begin
               pulses_d = pulses_q + K'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(negedge CLOCK or negedge CLEAR) begin
      if (!CLEAR) begin
         state_q  <= StIdle;
         div_q    <= '0;
         npulse_q <= '0;
         pulses_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         npulse_q <= npulse_d;
         pulses_q <= pulses_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.tick   = div_tick;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.pulses = pulses_q;

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Self-checking bench for pulse_burst_ctrl: a burst-level model checked every cycle,
// plus directed scenarios with hand-computed tick/done edge numbers.
module tb_pulse_burst_ctrl;

   localparam int unsigned M = 8;
   localparam int unsigned K = 8;

   logic CLOCK = 1'b1;
   logic CLEAR = 1'b0;

   pulse_burst_ctrl_if #(.M(M), .K(K)) bus ();

   pulse_burst_ctrl #(
      .M (M),
      .K (K)
   ) dut (
      .CLOCK (CLOCK),
      .CLEAR (CLEAR),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Burst model: t counts edges since the accepting edge; outputs follow from
   // the period/count arithmetic of the burst, not from a modulo counter.
   bit m_active, m_busy, m_tick, m_done, m_err;
   int m_t, m_d, m_n, m_pulses;

   always @(negedge CLOCK or negedge CLEAR) begin
      if (!CLEAR) begin
         m_active = 0; m_busy = 0; m_tick = 0; m_done = 0; m_err = 0;
         m_t = 0; m_d = 0; m_n = 0; m_pulses = 0;
      end else begin
         m_done = 0; m_err = 0; m_tick = 0;
         if (m_active) begin
            if (bus.abort) begin
               m_active = 0;
               m_busy   = 0;
            end else begin
               m_t++;
               if (m_t == m_n * m_d) begin
                  m_active = 0; m_busy = 0; m_done = 1; m_pulses = m_n;
               end else begin
                  m_tick   = ((m_t + 1) % m_d) == 0;
                  m_pulses = (m_t + 1) / m_d;
               end
            end
         end else if (bus.start) begin
            if (int'(bus.div) < 2 || bus.npulse == 0) begin
               m_err = 1;
            end else begin
               m_active = 1; m_t = 0; m_d = int'(bus.div); m_n = int'(bus.npulse);
               m_pulses = 0; m_busy = 1;
            end
         end
      end
   end

   logic [K+3:0] exp_v, act_v;
   always @(posedge CLOCK) begin
      if (CLEAR) begin
         exp_v = {m_busy, m_tick, m_done, m_err, K'(m_pulses)};
         act_v = {bus.busy, bus.tick, bus.done, bus.err, bus.pulses};
         n_checks++;
         if (act_v === exp_v) n_pass++;
         else $display("FAIL cycle {busy,tick,done,err,pulses}: got %h, expected %h (t=%0t)",
                       act_v, exp_v, $time);
      end
   end

   int rel, done_e, busy_cnt;
   int tq[$];

   function automatic int qget(input int i);
      return (tq.size() > i) ? tq[i] : -1;
   endfunction

   task automatic next_edge();
      @(negedge CLOCK);
      @(posedge CLOCK);
      #1;
   endtask

   task automatic clr_stats();
      rel      = 0;
      done_e   = -1;
      busy_cnt = bus.busy ? 1 : 0;
      tq.delete();
   endtask

   task automatic step();
      next_edge();
      rel++;
      if (bus.tick) tq.push_back(rel);
      if (bus.done && done_e < 0) done_e = rel;
      if (bus.busy) busy_cnt++;
   endtask

   task automatic start_burst(input int d, input int n);
      bus.start  = 1'b1;
      bus.div    = M'(d);
      bus.npulse = K'(n);
      next_edge();
      bus.start = 1'b0;
      clr_stats();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b1; bus.abort = 1'b0; bus.div = M'(5); bus.npulse = K'(3);
      CLEAR = 1'b0;

      // Reset held over two edges with START high.
      repeat (2) @(negedge CLOCK);
      #1;
      chk("reset_busy", bus.busy, 0);
      chk("reset_tick", bus.tick, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_err", bus.err, 0);
      chk("reset_pulses", bus.pulses, 0);
      @(posedge CLOCK);
      #1;
      bus.start = 1'b0;
      CLEAR = 1'b1;

      // Nominal burst DIV=5, NPULSE=3.
      start_burst(5, 3);
      repeat (16) step();
      chk("nom_ntick", tq.size(), 3);
      chk("nom_tick1", qget(0), 4);
      chk("nom_tick2", qget(1), 9);
      chk("nom_tick3", qget(2), 14);
      chk("nom_done", done_e, 15);
      chk("nom_busy_cycles", busy_cnt, 15);
      chk("nom_pulses", bus.pulses, 3);

      // Rejected starts.
      bus.start = 1'b1; bus.div = M'(1); bus.npulse = K'(4);
      next_edge();
      chk("rej1_err", bus.err, 1);
      chk("rej1_busy", bus.busy, 0);
      bus.start = 1'b0;
      next_edge();
      chk("rej1_err_clear", bus.err, 0);
      bus.start = 1'b1; bus.div = M'(6); bus.npulse = K'(0);
      next_edge();
      chk("rej2_err", bus.err, 1);
      chk("rej2_busy", bus.busy, 0);
      chk("rej2_pulses_kept", bus.pulses, 3);
      bus.start = 1'b0;
      next_edge();
      chk("rej2_err_clear", bus.err, 0);

      // Abort on the tick edge.
      start_burst(4, 2);
      step(); step();
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_tick", bus.tick, 0);
      chk("abort_pulses", bus.pulses, 0);
      chk("abort_busy", bus.busy, 0);
      repeat (6) step();
      chk("abort_ntick", tq.size(), 0);
      chk("abort_no_done", done_e, -1);

      // Inputs latched; START and DIV change during RUN ignored.
      start_burst(3, 2);
      bus.div = M'(7); bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (6) step();
      chk("latch_ntick", tq.size(), 2);
      chk("latch_tick1", qget(0), 2);
      chk("latch_tick2", qget(1), 5);
      chk("latch_done", done_e, 6);

      // Minimum period with START held: back-to-back bursts.
      bus.start = 1'b1; bus.div = M'(2); bus.npulse = K'(4);
      next_edge();
      clr_stats();
      repeat (9) step();
      chk("min_tick1", qget(0), 1);
      chk("min_tick2", qget(1), 3);
      chk("min_tick3", qget(2), 5);
      chk("min_tick4", qget(3), 7);
      chk("min_done", done_e, 8);
      chk("b2b_busy", bus.busy, 1);
      chk("b2b_busy_cycles", busy_cnt, 9);
      chk("b2b_pulses", bus.pulses, 0);
      bus.start = 1'b0; bus.abort = 1'b1;
      next_edge();
      bus.abort = 1'b0;
      chk("b2b_abort_busy", bus.busy, 0);

      // Asynchronous reset mid-burst.
      start_burst(5, 3);
      repeat (7) step();
      chk("mid_pulses", bus.pulses, 1);
      chk("mid_busy", bus.busy, 1);
      #2 CLEAR = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_tick", bus.tick, 0);
      chk("arst_pulses", bus.pulses, 0);
      chk("arst_done", bus.done, 0);
      repeat (2) @(negedge CLOCK);
      @(posedge CLOCK);
      #1;
      CLEAR = 1'b1;
      clr_stats();
      repeat (12) step();
      chk("arst_no_done", done_e, -1);
      chk("arst_no_busy", busy_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_burst_ctrl.md
Name: pulse_burst_ctrl

Overview:
- Controller that sequences a divide-by-N tick generator. On a START handshake it latches a divisor and a pulse count, then emits exactly that many one-cycle TICK pulses, each DIV clocks apart.
- After the last pulse it returns to idle and flags DONE.
- Sits between lab-board switch/keypad logic and downstream display or step logic that needs a bounded burst of slow ticks rather than a free-running divided clock.

Parameters:
- M, 8, width of divisor input DIV and of the internal modulo counter.
- K, 8, width of pulse-count input NPULSE and of the PULSES output.

Ports:
- CLOCK  input  1  system clock; all state updates on the falling edge.
- CLEAR  input  1  asynchronous, active-low reset.
- START  input  1  level-sampled request; accepted only in IDLE.
- ABORT  input  1  terminates a burst in RUN; ignored in IDLE.
- DIV  input  M  tick period in clocks; sampled with START.
- NPULSE  input  K  number of ticks in the burst; sampled with START.
- BUSY  output  1  high while in RUN.
- TICK  output  1  one-cycle pulse per period.
- DONE  output  1  one-cycle pulse on normal burst completion.
- ERR  output  1  one-cycle pulse on a rejected START.
- PULSES  output  K  ticks emitted in the current or last burst.

Behaviour:
- Reset: CLEAR low forces state=IDLE immediately, independent of CLOCK. It also clears the counter, the latched DIV/NPULSE, BUSY, TICK, DONE, ERR and PULSES to 0. Mid-burst resets abort silently, with no DONE.
- States: IDLE and RUN. All outputs are registered.
- IDLE, START=1 at an edge (E0):
  - If DIV<2 or NPULSE==0: ERR=1 for one cycle, stay in IDLE, PULSES unchanged.
  - Otherwise: latch DIV and NPULSE, set counter=0, PULSES=0, BUSY=1, enter RUN.
- IDLE defaults: DONE, TICK and ERR return to 0 on the next edge. ABORT has no effect.
- RUN, counter:
  - If counter==DIV-1, it goes to 0; otherwise it increments.
  - So at edge Ek (k<DIV) counter=k, with period DIV.
- RUN, tick:
  - On the edge where the counter goes from DIV-2 to DIV-1, TICK=1 and PULSES increments.
  - TICK=0 on all other edges.
  - First TICK rises at edge E(DIV-1), the n-th at E(n*DIV-1).
- RUN, completion:
  - On the edge where the counter wraps (DIV-1 to 0) and PULSES==latched NPULSE: state=IDLE, BUSY=0, DONE=1, TICK=0.
  - DONE therefore rises at E(NPULSE*DIV), one cycle after the last TICK.
  - BUSY is high for exactly NPULSE*DIV cycles.
- RUN, abort:
  - ABORT=1 at an edge: state=IDLE, BUSY=0, TICK=0, DONE=0, PULSES holds its value.
  - ABORT beats a coincident tick or completion on the same edge: no increment, no DONE.
- RUN, other inputs: START is ignored; changes to DIV or NPULSE have no effect until the next accepted START.
- Back-to-back bursts: START high on the edge after DONE is accepted normally. START held continuously restarts a burst every NPULSE*DIV+1 cycles.
- Width rules:
  - Counter is M bits; DIV-1 and DIV-2 are computed in M bits. DIV≥2 is guaranteed by the reject rule, so there is no underflow.
  - PULSES is K bits; the compare against NPULSE is exact, with no wrap, since NPULSE ≤ 2^K-1.
- Minimum period DIV=2: TICK alternates high/low every clock while running.

Decomposition:
- Shared package pulse_burst_pkg:
  - State enum {IDLE, RUN}.
  - Constant MIN_DIV=2.
  - Default widths M=8, K=8.
- Sub-module divide_prog:
  - Runtime-programmable modulo-DIV counter with inputs CLOCK, CLEAR, EN, SYNC_CLR, DIV[M], and output TICK.
  - TICK is registered and high on the DIV-2 to DIV-1 transition.
- pulse_burst_ctrl owns the FSM, the latches, the PULSES count and the completion/abort logic.

Test Plan:
- Reset: hold CLEAR=0 over two falling edges with START=1 -> all outputs 0. Assert CLEAR=0 asynchronously mid-burst (DIV=5, NPULSE=3, after 7 cycles) -> BUSY/TICK/PULSES go to 0 immediately, no DONE.
- Nominal burst: DIV=5, NPULSE=3, START pulse -> TICK high at E4, E9, E14; PULSES=1,2,3; DONE at E15; BUSY high for 15 cycles.
- Reject: DIV=1, NPULSE=4 -> ERR for one cycle, BUSY stays 0. Repeat with DIV=6, NPULSE=0 -> same result.
- Abort priority: DIV=4, NPULSE=2, ABORT=1 at E3 (the tick edge) -> no TICK, PULSES=0, BUSY=0, no DONE.
- Latch/ignore: DIV=3, NPULSE=2 started; at E1 change DIV=7 and pulse START -> ticks still at E2, E5, DONE at E6.
- Minimum period plus back-to-back: DIV=2, NPULSE=4, START held high -> TICK at E1, E3, E5, E7, DONE at E8, new burst accepted at E9.
